// File: rtl/y_sram_port.sv
// y_sram_port: Y-memory store, 2**ADDR_W x DATA_W array, two registered read ports, one write port.
// Ports:
//   clk, reset                  single clock; synchronous active-low reset
//   in_yReadAddress1/2          read port addresses (IDLE_ADDR = no read)
//   in_yWriteEnable             write strobe
//   in_yWriteAddress            write address (IDLE_ADDR = dropped write)
//   in_writeData                write data
//   op_readData1/2              read results (0 for idle reads)
//   op_readValid1/2             result is a real read
//   op_fwdHit                   a result in this beat came from same-cycle write forwarding
//   op_writeCount               committed-write count, saturating at 16'hffff
module y_sram_port #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 256,
    parameter int READ_LAT = 1,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 11'h7ff
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_yReadAddress1,
    input  logic [ADDR_W-1:0] in_yReadAddress2,
    input  logic              in_yWriteEnable,
    input  logic [ADDR_W-1:0] in_yWriteAddress,
    input  logic [DATA_W-1:0] in_writeData,
    output logic [DATA_W-1:0] op_readData1,
    output logic [DATA_W-1:0] op_readData2,
    output logic              op_readValid1,
    output logic              op_readValid2,
    output logic              op_fwdHit,
    output logic [15:0]       op_writeCount
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              commit, hit1, hit2, idle1, idle2;
    logic [DATA_W-1:0] rd1, rd2, s1Data1, s1Data2;
    logic              s1Valid1, s1Valid2, s1Fwd;

    // commit already excludes the idle address, so a hit is never an idle read
    always_comb begin
        commit = reset && in_yWriteEnable && in_yWriteAddress != IDLE_ADDR;
        idle1 = in_yReadAddress1 == IDLE_ADDR;
        idle2 = in_yReadAddress2 == IDLE_ADDR;
        hit1 = commit && in_yReadAddress1 == in_yWriteAddress;
        hit2 = commit && in_yReadAddress2 == in_yWriteAddress;
        rd1 = idle1 ? '0 : hit1 ? in_writeData : mem[in_yReadAddress1];
        rd2 = idle2 ? '0 : hit2 ? in_writeData : mem[in_yReadAddress2];
    end

    always_ff @(posedge clk)
        if (commit) mem[in_yWriteAddress] <= in_writeData;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1Data1 <= '0;
            s1Data2 <= '0;
            s1Valid1 <= 1'b0;
            s1Valid2 <= 1'b0;
            s1Fwd <= 1'b0;
        end else begin
            s1Data1 <= rd1;
            s1Data2 <= rd2;
            s1Valid1 <= !idle1;
            s1Valid2 <= !idle2;
            s1Fwd <= hit1 || hit2;
        end
    end

    always_ff @(posedge clk)
        op_writeCount <= !reset ? '0 : (commit && op_writeCount != 16'hffff) ? op_writeCount + 16'd1 : op_writeCount;

    // second stage only delays the already-resolved beat; later writes never touch it
    generate
        if (READ_LAT == 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (!reset) begin
                    op_readData1 <= '0;
                    op_readData2 <= '0;
                    op_readValid1 <= 1'b0;
                    op_readValid2 <= 1'b0;
                    op_fwdHit <= 1'b0;
                end else begin
                    op_readData1 <= s1Data1;
                    op_readData2 <= s1Data2;
                    op_readValid1 <= s1Valid1;
                    op_readValid2 <= s1Valid2;
                    op_fwdHit <= s1Fwd;
                end
            end
        end else begin : g_lat1
            assign op_readData1 = s1Data1;
            assign op_readData2 = s1Data2;
            assign op_readValid1 = s1Valid1;
            assign op_readValid2 = s1Valid2;
            assign op_fwdHit = s1Fwd;
        end
    endgenerate
endmodule

// File: doc/y_sram_port.md
# y_sram_port

Y-memory storage block at the far end of the Y bus arbitration path: accepts the arbitrated read addresses, write enable, write address and write data, and returns the two read-data words the compute and write paths consume. Holds a 2048 x 256-bit array with two read ports and one write port. Reads are registered, with write-first forwarding. The address 11'h7ff is the bus idle code, so a read or write at 11'h7ff is a no-op.

## Interface
- ADDR_W, 11, address width; array depth is 2**ADDR_W
- DATA_W, 256, data word width
- READ_LAT, 1, read latency in cycles; legal values are 1 and 2
- IDLE_ADDR, 11'h7ff, idle address code; never read from or written to the array
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset, sampled on the clk rising edge
- in_yReadAddress1  input  ADDR_W  read port 1 address
- in_yReadAddress2  input  ADDR_W  read port 2 address
- in_yWriteEnable  input  1  write strobe, one write per cycle
- in_yWriteAddress  input  ADDR_W  write address
- in_writeData  input  DATA_W  write data
- op_readData1  output  DATA_W  read port 1 data
- op_readData2  output  DATA_W  read port 2 data
- op_readValid1  output  1  op_readData1 holds a real (non-idle) read result
- op_readValid2  output  1  op_readData2 holds a real (non-idle) read result
- op_fwdHit  output  1  at least one read in the current output beat was served by forwarding
- op_writeCount  output  16  count of committed writes, saturating at 16'hffff

## Operation
- Write commit:
  - Occurs on a rising edge when reset=1, in_yWriteEnable=1 and in_yWriteAddress != IDLE_ADDR.
  - Stores in_writeData at mem[in_yWriteAddress].
  - Increments op_writeCount by 1 unless it is already 16'hffff.
  - A write with in_yWriteAddress = IDLE_ADDR is dropped and does not count.
- Read issue (evaluated per port, independently, each cycle):
  - Idle read (address = IDLE_ADDR): result data is 0 and valid is 0.
  - Forwarded read (a write commits in the same cycle to the same address): result data is in_writeData (write-first) and valid is 1.
  - Otherwise: result data is mem[address] as it was before this edge's write, and valid is 1.
- Both read ports may name the same address; each port returns the same data.
- op_fwdHit is 1 for the output beat in which either port's result came from forwarding.
- Array contents are not cleared by reset. Reading a never-written location returns X in simulation; benches write every location before reading it.
- No stall or back-pressure: every cycle issues a fresh read on both ports.
- The block does not know which upstream path owns the bus; arbitration is entirely upstream.

## Timing
- READ_LAT=1:
  - Address sampled on edge N; data, valid and op_fwdHit are visible after edge N.
  - Outputs are registered and hold until edge N+1.
- READ_LAT=2:
  - Adds one output register stage; results become visible after edge N+1.
  - Forwarding is resolved at edge N; the second stage does not re-check later writes.
  - A write at edge N+1 to the same address does not alter the in-flight result.
- Write-then-read: a write committed at edge N is visible to a non-forwarded read issued at edge N+1.
- Reset (reset=0 sampled at an edge):
  - op_readData1/2 = 0, op_readValid1/2 = 0, op_fwdHit = 0, op_writeCount = 0.
  - All pipeline stages are cleared.
  - No write commits that cycle, even if in_yWriteEnable=1.
- Reset mid-operation:
  - In-flight reads are discarded.
  - The first valid output is from an address sampled at the first edge with reset=1.
- Saturation: op_writeCount holds at 16'hffff; it never wraps to 0.

## Test plan
- Reset: hold reset=0 for 3 cycles with in_yWriteEnable=1, in_yWriteAddress=11'h005 -> all outputs 0, op_writeCount=0. A later read of 11'h005 returns its prior contents, not the write data from the reset cycles.
- Basic write/read, READ_LAT=1: write 256'hA5 to 11'h010 at edge N, then read port 1 at 11'h010 at edge N+1 -> op_readData1=256'hA5, op_readValid1=1 after edge N+1; op_fwdHit=0.
- Forwarding: same edge writes 256'h1234 to 11'h020 while both read ports address 11'h020, where mem[11'h020]=256'h99 beforehand -> both ports return 256'h1234, both valids 1, op_fwdHit=1.
- Idle code: write 256'hFF to 11'h7ff while reading 11'h7ff on port 2 -> op_readData2=0, op_readValid2=0, op_writeCount unchanged; a subsequent read of 11'h7fe is unaffected.
- READ_LAT=2 with mid-flight reset: issue a read of 11'h030 at edge N, assert reset=0 at edge N+1 -> outputs 0 after edge N+1. A read reissued at edge N+2 returns data after edge N+3.
- Saturation: preload op_writeCount to 16'hfffe via 16'hfffe non-idle writes, then perform 3 more writes -> op_writeCount = 16'hffff and stays there.
